// File: rtl/ad7357_pkg.sv
// Shared frame geometry, FSM state type and frame-building helper for the
// AD7357 responder-side emulator.
package ad7357_pkg;

    // Sample width, leading-zero count and total SDATA frame length.
    localparam int unsigned AD7357_DATA_W     = 14;
    localparam int unsigned AD7357_LEAD_ZEROS = 2;
    localparam int unsigned AD7357_FRAME_LEN  = AD7357_LEAD_ZEROS + AD7357_DATA_W;

    // Width of the per-frame bit counter.
    localparam int unsigned AD7357_CNT_W = $clog2(AD7357_FRAME_LEN);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        TRAIL
    } ad7357_state_e;

    // Full serial frame for one channel, MSB first: leading zeros then sample.
    function automatic logic [AD7357_FRAME_LEN-1:0] ad7357_frame(
        input logic [AD7357_DATA_W-1:0] sample
    );
        return {{AD7357_LEAD_ZEROS{1'b0}}, sample};
    endfunction

endpackage

// File: rtl/ad7357_emu_ramp.sv
// Internal test-pattern source: a free-running 14-bit counter that advances
// once per frame start. A carries the count, B its bitwise complement.
module ad7357_emu_ramp
    import ad7357_pkg::*;
(
    input  logic                     i_sclk,
    input  logic                     i_rst,
    input  logic                     i_advance,
    output logic [AD7357_DATA_W-1:0] o_ramp_a,
    output logic [AD7357_DATA_W-1:0] o_ramp_b
);

    logic [AD7357_DATA_W-1:0] count_q;
    logic [AD7357_DATA_W-1:0] count_d;

    // Advance on strobe; natural wrap from all-ones back to zero.
    always_comb begin
        count_d = count_q;
        if (i_advance) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_ramp_a = count_q;
    assign o_ramp_b = ~count_q;

endmodule

// File: rtl/ad7357_emu.sv
// Responder-side model of the AD7357 dual serial ADC. Runs entirely on the
// host's SCLK. A frame starts on the first posedge that sees CS_n low; each
// following posedge shifts out one bit per channel (2 zeros + 14 data bits),
// then zeros are driven until CS_n rises.
//
// Build option: define AD7357_EMU_RAMP_EN to replace the upstream valid/ready
// source with an internal ramp (A = count, B = ~count).
module ad7357_emu
    import ad7357_pkg::*;
(
    input  logic                     i_sclk,
    input  logic                     i_rst,
    input  logic                     i_cs_n,
    output logic                     o_sdata_a,
    output logic                     o_sdata_b,
    output logic                     o_sdata_oe,
    input  logic [AD7357_DATA_W-1:0] i_sample_a,
    input  logic [AD7357_DATA_W-1:0] i_sample_b,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic                     o_underrun,
    output logic                     o_abort,
    output logic                     o_done
);

    ad7357_state_e state_q, state_d;
    logic [AD7357_CNT_W-1:0]     cnt_q, cnt_d;
    logic [AD7357_FRAME_LEN-1:0] shift_a_q, shift_a_d;
    logic [AD7357_FRAME_LEN-1:0] shift_b_q, shift_b_d;
    logic sdata_a_q, sdata_a_d;
    logic sdata_b_q, sdata_b_d;
    logic oe_q, oe_d;
    logic underrun_q, underrun_d;
    logic abort_q, abort_d;
    logic done_q, done_d;

    // Pair to load at frame start and whether it is fresh.
    logic [AD7357_DATA_W-1:0]    src_a, src_b;
    logic                        src_fresh;
    logic [AD7357_FRAME_LEN-1:0] frame_a, frame_b;
    logic                        frame_start;

    assign frame_start = (state_q == IDLE) && !i_cs_n;
    assign frame_a     = ad7357_frame(src_a);
    assign frame_b     = ad7357_frame(src_b);

`ifdef AD7357_EMU_RAMP_EN

    // Upstream port is ignored in ramp mode.
    logic unused_upstream;
    assign unused_upstream = ^{i_sample_a, i_sample_b, i_valid};

    ad7357_emu_ramp u_ramp (
        .i_sclk    (i_sclk),
        .i_rst     (i_rst),
        .i_advance (frame_start),
        .o_ramp_a  (src_a),
        .o_ramp_b  (src_b)
    );

    // The ramp always has a fresh pair, so underrun can never occur.
    assign src_fresh = 1'b1;
    assign o_ready   = 1'b0;

`else

    logic                     hold_valid_q, hold_valid_d;
    logic [AD7357_DATA_W-1:0] hold_a_q, hold_a_d;
    logic [AD7357_DATA_W-1:0] hold_b_q, hold_b_d;
    logic [AD7357_DATA_W-1:0] last_a_q, last_a_d;
    logic [AD7357_DATA_W-1:0] last_b_q, last_b_d;
    logic                     ready_q, ready_d;
    logic                     transfer;

    assign transfer = i_valid && ready_q;

    // Holding register: consumed at frame start, refilled by the handshake.
    // A transfer can only happen while empty, so it never collides with a
    // consume in the same cycle; it lands for the next frame.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_a_d     = hold_a_q;
        hold_b_d     = hold_b_q;
        last_a_d     = last_a_q;
        last_b_d     = last_b_q;
        if (frame_start && hold_valid_q) begin
            hold_valid_d = 1'b0;
            last_a_d     = hold_a_q;
            last_b_d     = hold_b_q;
        end
        if (transfer) begin
            hold_valid_d = 1'b1;
            hold_a_d     = i_sample_a;
            hold_b_d     = i_sample_b;
        end
        ready_d = !hold_valid_d;
    end

    // Holding and last-pair registers.
    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            hold_valid_q <= 1'b0;
            hold_a_q     <= '0;
            hold_b_q     <= '0;
            last_a_q     <= '0;
            last_b_q     <= '0;
            ready_q      <= 1'b1;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_a_q     <= hold_a_d;
            hold_b_q     <= hold_b_d;
            last_a_q     <= last_a_d;
            last_b_q     <= last_b_d;
            ready_q      <= ready_d;
        end
    end

    // Without a fresh pair the previous one is replayed.
    assign src_fresh = hold_valid_q;
    assign src_a     = hold_valid_q ? hold_a_q : last_a_q;
    assign src_b     = hold_valid_q ? hold_b_q : last_b_q;
    assign o_ready   = ready_q;

`endif

    // Frame FSM next state and registered serial outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_a_d  = shift_a_q;
        shift_b_d  = shift_b_q;
        sdata_a_d  = 1'b0;
        sdata_b_d  = 1'b0;
        oe_d       = 1'b0;
        underrun_d = 1'b0;
        abort_d    = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!i_cs_n) begin
                    // Bit 0 goes out on this same edge; the rest queue behind it.
                    state_d    = SHIFT;
                    cnt_d      = AD7357_CNT_W'(1);
                    sdata_a_d  = frame_a[AD7357_FRAME_LEN-1];
                    sdata_b_d  = frame_b[AD7357_FRAME_LEN-1];
                    shift_a_d  = frame_a << 1;
                    shift_b_d  = frame_b << 1;
                    oe_d       = 1'b1;
                    underrun_d = !src_fresh;
                end
            end
            SHIFT: begin
                if (i_cs_n) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else begin
                    oe_d      = 1'b1;
                    sdata_a_d = shift_a_q[AD7357_FRAME_LEN-1];
                    sdata_b_d = shift_b_q[AD7357_FRAME_LEN-1];
                    shift_a_d = shift_a_q << 1;
                    shift_b_d = shift_b_q << 1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == AD7357_CNT_W'(AD7357_FRAME_LEN - 1)) begin
                        state_d = TRAIL;
                    end
                end
            end
            TRAIL: begin
                if (i_cs_n) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    oe_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and output registers.
    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_a_q  <= '0;
            shift_b_q  <= '0;
            sdata_a_q  <= 1'b0;
            sdata_b_q  <= 1'b0;
            oe_q       <= 1'b0;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_a_q  <= shift_a_d;
            shift_b_q  <= shift_b_d;
            sdata_a_q  <= sdata_a_d;
            sdata_b_q  <= sdata_b_d;
            oe_q       <= oe_d;
            underrun_q <= underrun_d;
            abort_q    <= abort_d;
            done_q     <= done_d;
        end
    end

    assign o_sdata_a  = sdata_a_q;
    assign o_sdata_b  = sdata_b_q;
    assign o_sdata_oe = oe_q;
    assign o_underrun = underrun_q;
    assign o_abort    = abort_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_ad7357_emu.sv
// Bench for ad7357_emu: emulates the host (CS_n/SCLK, sampling SDATA on
// negedge) and checks frames against a scoreboard of expected pairs.
module tb_ad7357_emu;

    logic        i_sclk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_cs_n = 1'b1;
    logic [13:0] i_sample_a = '0;
    logic [13:0] i_sample_b = '0;
    logic        i_valid = 1'b0;
    logic        o_sdata_a, o_sdata_b, o_sdata_oe;
    logic        o_ready, o_underrun, o_abort, o_done;

    int n_checks = 0;
    int n_fail = 0;
    int ur_pulses = 0;

    typedef struct packed {
        logic [13:0] a;
        logic [13:0] b;
        logic        ur;
    } exp_t;

    typedef struct {
        logic [13:0] a;
        logic [13:0] b;
    } vec_t;

    exp_t        exp_q[$];
    logic [13:0] model_last_a = '0;
    logic [13:0] model_last_b = '0;

    ad7357_emu dut (
        .i_sclk     (i_sclk),
        .i_rst      (i_rst),
        .i_cs_n     (i_cs_n),
        .o_sdata_a  (o_sdata_a),
        .o_sdata_b  (o_sdata_b),
        .o_sdata_oe (o_sdata_oe),
        .i_sample_a (i_sample_a),
        .i_sample_b (i_sample_b),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_underrun (o_underrun),
        .o_abort    (o_abort),
        .o_done     (o_done)
    );

    always #5 i_sclk = ~i_sclk;

    // Count every underrun pulse seen over the whole run.
    always @(posedge i_sclk) begin
        #1;
        if (o_underrun === 1'b1) ur_pulses++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exhausted, expected test completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_fresh(input logic [13:0] a, input logic [13:0] b);
        exp_q.push_back('{a: a, b: b, ur: 1'b0});
        model_last_a = a;
        model_last_b = b;
    endtask

    task automatic expect_underrun();
        exp_q.push_back('{a: model_last_a, b: model_last_b, ur: 1'b1});
    endtask

    // Offer a pair upstream and wait (bounded) for it to be accepted.
    task automatic send_pair(input logic [13:0] a, input logic [13:0] b);
        bit ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge i_sclk);
            if (o_ready === 1'b1) begin
                i_valid = 1'b1;
                i_sample_a = a;
                i_sample_b = b;
                ok = 1'b1;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_timeout: o_ready=%0b after 50 cycles, expected 1", o_ready);
        end else begin
            @(negedge i_sclk);
            i_valid = 1'b0;
            check("ready_after_accept", 32'(o_ready), 32'd0);
        end
    endtask

    // One host frame of nbits sampling negedges; optionally offers a pair at N0.
    task automatic run_frame(input int nbits, input logic pv,
                             input logic [13:0] pa, input logic [13:0] pb,
                             output logic [15:0] cap_a, output logic [15:0] cap_b,
                             output logic tail_nz, output logic ur, output logic rdy,
                             output logic all_oe, output logic done, output logic abort,
                             output logic oe_after);
        cap_a = '0;
        cap_b = '0;
        tail_nz = 1'b0;
        all_oe = 1'b1;
        @(negedge i_sclk);
        i_cs_n = 1'b0;
        if (pv) begin
            i_valid = 1'b1;
            i_sample_a = pa;
            i_sample_b = pb;
        end
        @(posedge i_sclk);
        #1;
        ur = o_underrun;
        rdy = o_ready;
        i_valid = 1'b0;
        for (int k = 1; k <= nbits; k++) begin
            @(negedge i_sclk);
            if (k <= 16) begin
                cap_a = {cap_a[14:0], o_sdata_a};
                cap_b = {cap_b[14:0], o_sdata_b};
            end else begin
                tail_nz = tail_nz | o_sdata_a | o_sdata_b;
            end
            all_oe = all_oe & o_sdata_oe;
            if (k == nbits) i_cs_n = 1'b1;
        end
        @(posedge i_sclk);
        #1;
        done = o_done;
        abort = o_abort;
        oe_after = o_sdata_oe;
    endtask

    // Complete 16-bit frame checked against the scoreboard head.
    task automatic full_frame(input logic pv, input logic [13:0] pa, input logic [13:0] pb,
                              input logic exp_rdy);
        logic [15:0] ca, cb;
        logic tnz, ur, rdy, aoe, dn, ab, oea;
        exp_t e;
        run_frame(16, pv, pa, pb, ca, cb, tnz, ur, rdy, aoe, dn, ab, oea);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 expected entries, required at least 1");
        end else begin
            e = exp_q.pop_front();
            check("frame_a", 32'(ca), 32'({2'b00, e.a}));
            check("frame_b", 32'(cb), 32'({2'b00, e.b}));
            check("underrun_at_p1", 32'(ur), 32'(e.ur));
            check("ready_after_p1", 32'(rdy), 32'(exp_rdy));
            check("oe_during_frame", 32'(aoe), 32'd1);
            check("done_at_end", 32'(dn), 32'd1);
            check("no_abort", 32'(ab), 32'd0);
            check("oe_off_after", 32'(oea), 32'd0);
        end
        @(posedge i_sclk);
        #1;
        check("done_one_cycle", 32'(o_done), 32'd0);
    endtask

    initial begin
        vec_t vecs[6];
        logic [15:0] ca, cb;
        logic tnz, ur, rdy, aoe, dn, ab, oea;
        exp_t e;
        logic [15:0] fa;

        vecs[0] = '{a: 14'h2ABC, b: 14'h1543};
        vecs[1] = '{a: 14'h3FFF, b: 14'h0000};
        vecs[2] = '{a: 14'h0000, b: 14'h3FFF};
        vecs[3] = '{a: 14'h2000, b: 14'h0001};
        vecs[4] = '{a: 14'h1234, b: 14'h2DCB};
        vecs[5] = '{a: 14'h0001, b: 14'h3FFF};

        repeat (3) @(posedge i_sclk);
        @(negedge i_sclk);
        check("rst_sdata_a", 32'(o_sdata_a), 32'd0);
        check("rst_sdata_b", 32'(o_sdata_b), 32'd0);
        check("rst_oe", 32'(o_sdata_oe), 32'd0);
        check("rst_pulses", 32'({o_underrun, o_abort, o_done}), 32'd0);
`ifdef AD7357_EMU_RAMP_EN
        check("rst_ready", 32'(o_ready), 32'd0);
`else
        check("rst_ready", 32'(o_ready), 32'd1);
`endif
        i_rst = 1'b0;

`ifdef AD7357_EMU_RAMP_EN
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{a: 14'(i), b: ~14'(i), ur: 1'b0});
            full_frame(1'b0, '0, '0, 1'b0);
        end
        check("ramp_no_underrun", 32'(ur_pulses), 32'd0);
`else
        // Table of fresh pairs, one frame each.
        for (int i = 0; i < 6; i++) begin
            send_pair(vecs[i].a, vecs[i].b);
            expect_fresh(vecs[i].a, vecs[i].b);
            full_frame(1'b0, '0, '0, 1'b1);
        end

        // No new pair: last pair replayed with an underrun pulse.
        expect_underrun();
        full_frame(1'b0, '0, '0, 1'b1);

        // CS_n raised after 7 bits: abort, no done, then a clean frame.
        send_pair(14'h0ABC, 14'h3543);
        expect_fresh(14'h0ABC, 14'h3543);
        run_frame(7, 1'b0, '0, '0, ca, cb, tnz, ur, rdy, aoe, dn, ab, oea);
        e = exp_q.pop_front();
        fa = {2'b00, e.a};
        check("abort_bits_a", 32'(ca), 32'(fa >> 9));
        fa = {2'b00, e.b};
        check("abort_bits_b", 32'(cb), 32'(fa >> 9));
        check("abort_pulse", 32'(ab), 32'd1);
        check("abort_no_done", 32'(dn), 32'd0);
        check("abort_oe_off", 32'(oea), 32'd0);
        @(posedge i_sclk);
        #1;
        check("abort_one_cycle", 32'(o_abort), 32'd0);
        send_pair(14'h1111, 14'h2222);
        expect_fresh(14'h1111, 14'h2222);
        full_frame(1'b0, '0, '0, 1'b1);

        // CS_n held for 20 negedges: trailing zeros with oe held.
        send_pair(14'h3333, 14'h0CCC);
        expect_fresh(14'h3333, 14'h0CCC);
        run_frame(20, 1'b0, '0, '0, ca, cb, tnz, ur, rdy, aoe, dn, ab, oea);
        e = exp_q.pop_front();
        check("long_frame_a", 32'(ca), 32'({2'b00, e.a}));
        check("long_frame_b", 32'(cb), 32'({2'b00, e.b}));
        check("long_tail_zero", 32'(tnz), 32'd0);
        check("long_oe_held", 32'(aoe), 32'd1);
        check("long_done", 32'(dn), 32'd1);
        check("long_no_abort", 32'(ab), 32'd0);

        // Pair offered on the frame-start edge with an empty hold.
        expect_underrun();
        expect_fresh(14'h3C3C, 14'h03C3);
        full_frame(1'b1, 14'h3C3C, 14'h03C3, 1'b0);
        full_frame(1'b0, '0, '0, 1'b1);

        // Reset mid-frame with a pair waiting in the hold register.
        send_pair(14'h1F0F, 14'h20F0);
        @(negedge i_sclk);
        i_cs_n = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge i_sclk);
            if (k == 3) begin
                i_valid = 1'b1;
                i_sample_a = 14'h2468;
                i_sample_b = 14'h1357;
            end
            if (k == 4) begin
                i_valid = 1'b0;
                check("hold_full_before_rst", 32'(o_ready), 32'd0);
            end
            if (k == 9) begin
                i_rst = 1'b1;
                i_cs_n = 1'b1;
            end
        end
        @(posedge i_sclk);
        #1;
        check("rst_mid_oe", 32'(o_sdata_oe), 32'd0);
        check("rst_mid_ready", 32'(o_ready), 32'd1);
        check("rst_mid_pulses", 32'({o_underrun, o_abort, o_done}), 32'd0);
        @(negedge i_sclk);
        i_rst = 1'b0;
        model_last_a = '0;
        model_last_b = '0;
        expect_underrun();
        full_frame(1'b0, '0, '0, 1'b1);

        check("underrun_total", 32'(ur_pulses), 32'd3);
`endif

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ad7357_emu.md
# ad7357_emu

Synthesizable responder-side model of the AD7357 dual 14-bit serial ADC. It reacts to CS_n and SCLK from the AD7357 host interface and drives the two SDATA lines with 2 leading zeros followed by 14 data bits, MSB-first, per channel. Its uses are on-board loopback of the capture path, with no ADC fitted, and closed-loop simulation of the acquisition chain. Sample pairs come from an upstream valid/ready source or, optionally, from an internal ramp generator.

## Interface
Parameters: none. Frame geometry lives in the package.

Ports:
- i_sclk  in  1  interface clock, the same net the host uses; whole block on `posedge i_sclk`
- i_rst  in  1  reset, synchronous, active-high
- i_cs_n  in  1  chip select from host; host changes it on negedge
- o_sdata_a  out  1  channel A serial data
- o_sdata_b  out  1  channel B serial data
- o_sdata_oe  out  1  output enable for both SDATA pads; low = three-state
- i_sample_a  in  14  upstream channel A sample
- i_sample_b  in  14  upstream channel B sample
- i_valid  in  1  upstream sample pair valid
- o_ready  out  1  holding register empty
- o_underrun  out  1  1-cycle pulse: frame started with no fresh sample pair
- o_abort  out  1  1-cycle pulse: CS_n rose before 16 bits were sent
- o_done  out  1  1-cycle pulse: CS_n rose after a complete frame

## Operation
- Holding register:
  - Transfer occurs when i_valid && o_ready; the pair is stored and hold_valid is set.
  - o_ready = !hold_valid, registered.
- States and transitions:
  - IDLE:
    - oe = 0, sdata = 0.
    - On a posedge with i_cs_n = 0, go to SHIFT with bit counter 0.
    - If hold_valid, load the holding pair into the shift registers and clear hold_valid.
    - Otherwise reload the last loaded pair (zeros after reset) and pulse o_underrun.
  - SHIFT:
    - Frame bit k (k = 0..15) is driven during the posedge interval k+1 after CS_n is seen low.
    - Bits 0 and 1 are 0; bits 2..15 are sample[13:0], MSB-first.
    - After bit 15, go to TRAIL.
    - i_cs_n = 1 in SHIFT: go to IDLE and pulse o_abort.
  - TRAIL:
    - Drive 0 while CS_n stays low.
    - i_cs_n = 1: go to IDLE and pulse o_done.
- o_sdata_oe = 1 in SHIFT and TRAIL, 0 in IDLE.
- Upstream handshake is independent of state.
  - An i_valid transfer in the same cycle as a frame start with an empty holding register is stored for the next frame; the current frame still underruns.
- Reset mid-frame:
  - Next state is IDLE and oe drops.
  - Holding register and last-pair register clear.
  - No pulses are generated.

## Timing
- Host sequence: negedge N0 drives CS_n low; the host samples at N1..N16 and raises CS_n at N16.
- Block response:
  - Posedge P1 (between N0 and N1) detects CS_n low and drives frame bit 0.
  - Pk drives bit k-1, giving half an SCLK of setup to Nk.
  - P17 sees CS_n high, returns to IDLE and pulses o_done.
- Reset values: o_sdata_a/b = 0, o_sdata_oe = 0, o_ready = 1, o_underrun/o_abort/o_done = 0.
- Output latency from CS_n low to first driven bit: 1 posedge.
- All outputs are registered; there are no combinational paths from inputs.

## Configuration
- AD7357_EMU_RAMP_EN defined:
  - The internal ramp replaces the upstream source.
  - Each frame start loads A = counter, B = ~counter, then increments the 14-bit counter, wrapping 0x3FFF -> 0x0000.
  - The counter is 0 after reset.
  - o_underrun never pulses and o_ready is held 0.
  - i_sample_a/b and i_valid are ignored.
- Undefined: the upstream holding-register path as described above.

## Structure
- Package ad7357_pkg:
  - AD7357_DATA_W = 14, AD7357_LEAD_ZEROS = 2, AD7357_FRAME_LEN = 16.
  - State enum IDLE/SHIFT/TRAIL.
- One sub-module, ad7357_emu_ramp: 14-bit counter with advance strobe, producing A/B outputs. Instantiated only under AD7357_EMU_RAMP_EN.

## Test plan
- Pair A=0x2ABC, B=0x1543 accepted, then a 16-negedge host frame -> sampled bits 00 + 0x2ABC / 00 + 0x1543; o_done pulses at P17; o_ready returns to 1 after P1.
- Two frames with no new i_valid after the first pair 0x0001/0x3FFF -> second frame repeats 0x0001/0x3FFF and o_underrun pulses at its P1.
- CS_n raised after 7 negedges -> o_abort pulse, oe = 0 next posedge, no o_done; the next full frame is correct.
- CS_n held low for 20 negedges -> bits 16..19 are 0, oe stays 1, o_done only after CS_n rises.
- i_rst asserted at bit 9 -> IDLE, oe = 0, o_ready = 1; the next frame with an empty hold returns 0x0000/0x0000 and pulses o_underrun.
- With AD7357_EMU_RAMP_EN defined, 3 frames after reset -> A = 0,1,2 and B = 0x3FFF,0x3FFE,0x3FFD; o_underrun never pulses.
